// File: rtl/meta_stim_monitor_if.sv
// Bundle of the run-control, stimulus and result signals between meta_stim_monitor
// and its controller/test circuit; slave is the monitor's view, master the opposite end.
interface meta_stim_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [WIDTH-1:0] async_out;
  logic [WIDTH-1:0] qd_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] lane_err;
  logic [CNT_W-1:0] first_err_idx;

  modport slave (
    input  start, num_vectors, qd_in,
    output async_out, busy, done, err_count, lane_err, first_err_idx
  );

  modport master (
    output start, num_vectors, qd_in,
    input  async_out, busy, done, err_count, lane_err, first_err_idx
  );
endinterface

// File: rtl/meta_stim_monitor.sv
// LFSR stimulus generator and Qd mismatch checker for the metastability test circuit.
// Optional first-error index capture is built when META_MON_FIRST_ERR_EN is defined.
module meta_stim_monitor #(
  parameter int          WIDTH = 4,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic             clk,
  input logic             rst_n,
  meta_stim_monitor_if.slave bus
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [2:0]       state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] nv_lat;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [WIDTH-1:0] async_q;
  logic [CNT_W-1:0] err_q;
  logic [WIDTH-1:0] lane_q;
  logic             start_ok;
  logic             in_window;
  logic             hit;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  assign start_ok  = (state == ST_IDLE) && bus.start;
  assign in_window = (state == ST_RUN) || (state == ST_DRAIN);
  assign hit       = in_window && (|bus.qd_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      nv_lat    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_FLUSH;
            nv_lat    <= bus.num_vectors;
            phase_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (phase_cnt == FLUSH_LAST) begin
            phase_cnt <= '0;
            state     <= (nv_lat == '0) ? ST_DRAIN : ST_RUN;
          end else begin
            phase_cnt <= phase_cnt + ONE;
          end
        end
        ST_RUN: begin
          if (phase_cnt == nv_lat - ONE) begin
            phase_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            phase_cnt <= phase_cnt + ONE;
          end
        end
        ST_DRAIN: begin
          if (phase_cnt == DRAIN_LAST) begin
            phase_cnt <= '0;
            state     <= ST_DONE;
          end else begin
            phase_cnt <= phase_cnt + ONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  // async_out mirrors the LFSR once it starts stepping and holds outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= SEED_EFF;
      async_q <= '0;
    end else if (start_ok) begin
      lfsr <= SEED_EFF;
    end else if (state == ST_RUN) begin
      lfsr    <= lfsr_next;
      async_q <= lfsr_next[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      lane_q <= '0;
    end else if (start_ok) begin
      err_q  <= '0;
      lane_q <= '0;
    end else if (hit) begin
      if (err_q != CNT_MAX) begin
        err_q <= err_q + ONE;
      end
      lane_q <= lane_q | bus.qd_in;
    end
  end

`ifdef META_MON_FIRST_ERR_EN
  logic [CNT_W-1:0] win_idx;
  logic [CNT_W-1:0] fe_idx;
  logic             fe_seen;

  // all-ones doubles as the "no error this run" marker until the first hit lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_idx <= '0;
      fe_idx  <= '0;
      fe_seen <= 1'b0;
    end else if (start_ok) begin
      win_idx <= '0;
      fe_idx  <= CNT_MAX;
      fe_seen <= 1'b0;
    end else if (in_window) begin
      if (hit && !fe_seen) begin
        fe_idx  <= win_idx;
        fe_seen <= 1'b1;
      end
      if (win_idx != CNT_MAX) begin
        win_idx <= win_idx + ONE;
      end
    end
  end

  assign bus.first_err_idx = fe_idx;
`else
  assign bus.first_err_idx = '0;
`endif

  assign bus.async_out = async_q;
  assign bus.err_count = err_q;
  assign bus.lane_err  = lane_q;
  assign bus.busy      = (state == ST_FLUSH) || (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_meta_stim_monitor.sv
// Randomized self-checking bench for meta_stim_monitor against a cycle-phase reference model.
module tb_meta_stim_monitor;

  localparam int W    = 4;
  localparam int CW   = 16;
  localparam int SCW  = 4;
  localparam int MAXK = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  meta_stim_monitor_if #(.WIDTH(W), .CNT_W(CW))  bus ();
  meta_stim_monitor_if #(.WIDTH(W), .CNT_W(SCW)) sbus ();

  meta_stim_monitor #(.WIDTH(W), .CNT_W(CW), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // narrow counter and zero seed exercise saturation and seed substitution
  meta_stim_monitor #(.WIDTH(W), .CNT_W(SCW), .SEED(16'h0000)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] pat      [0:MAXK-1];
  logic       busy_obs [0:MAXK-1];
  logic       done_obs [0:MAXK-1];
  logic [3:0] aout_obs [0:MAXK-1];
  int         done_k;
  logic [3:0] model_aout = 4'h0;

  function automatic logic [15:0] lfsr_after(input logic [15:0] s, input int steps);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < steps; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return v;
  endfunction

  // period k after the start edge: 0..2 flush, 3..n+2 run, n+3..n+4 drain, n+5 done
  function automatic logic [3:0] exp_aout(input int k, input int n, input logic [3:0] prev);
    int          steps;
    logic [15:0] s;
    steps = (k < 3) ? 0 : (((k - 3) < n) ? (k - 3) : n);
    if (steps == 0) return prev;
    s = lfsr_after(16'hACE1, steps);
    return s[3:0];
  endfunction

  task automatic model_results(input int n, output logic [15:0] ecnt,
                               output logic [3:0] elanes, output logic [15:0] efirst);
`ifdef META_MON_FIRST_ERR_EN
    bit seen;
    seen = 1'b0;
    efirst = 16'hFFFF;
`else
    efirst = 16'h0000;
`endif
    ecnt = 16'h0;
    elanes = 4'h0;
    for (int k = 3; k < n + 5; k++) begin
      if (pat[k] != 4'h0) begin
        if (ecnt != 16'hFFFF) ecnt = ecnt + 16'h1;
        elanes = elanes | pat[k];
`ifdef META_MON_FIRST_ERR_EN
        if (!seen) begin
          efirst = 16'(k - 3);
          seen = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic clear_pat();
    for (int k = 0; k < MAXK; k++) pat[k] = 4'h0;
  endtask

  // drives one run from period alignment (#1 after an edge) and records per-period outputs
  task automatic do_run(input int n, input bit poke);
    bus.num_vectors = 16'(n);
    bus.start = 1'b1;
    bus.qd_in = 4'h0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.num_vectors = 16'($urandom);
    done_k = -1;
    for (int k = 0; k < n + 8; k++) begin
      busy_obs[k] = bus.busy;
      done_obs[k] = bus.done;
      aout_obs[k] = bus.async_out;
      if (bus.done && done_k < 0) done_k = k;
      bus.qd_in = pat[k];
      bus.start = poke && (k == 1 || k == 3 + n / 2 || k == n + 5);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.qd_in = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.num_vectors = '0; bus.qd_in = '0;
    sbus.start = 1'b0; sbus.num_vectors = '0; sbus.qd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 7;
    if (bus.async_out !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_async_out got %h want 0", bus.async_out); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    if (bus.err_count !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_err_count got %h want 0", bus.err_count); end
    if (bus.lane_err !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_lane_err got %h want 0", bus.lane_err); end
    if (bus.first_err_idx !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_first_err_idx got %h want 0", bus.first_err_idx); end
    if (sbus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_small_busy got %b want 0", sbus.busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_aout = 4'h0;
  endtask

  task automatic test_healthy();
    logic [15:0] ecnt, efirst;
    logic [3:0]  elanes, ea;
    int          n;
    n = 100;
    clear_pat();
    do_run(n, 1'b0);
    model_results(n, ecnt, elanes, efirst);
    n_cmp += 4;
    if (done_k !== n + 5) begin n_bad++; $display("[TB] FAIL healthy_done_period got %0d want %0d", done_k, n + 5); end
    if (bus.err_count !== ecnt) begin n_bad++; $display("[TB] FAIL healthy_err_count got %h want %h", bus.err_count, ecnt); end
    if (bus.lane_err !== elanes) begin n_bad++; $display("[TB] FAIL healthy_lane_err got %h want %h", bus.lane_err, elanes); end
    if (bus.first_err_idx !== efirst) begin n_bad++; $display("[TB] FAIL healthy_first_err got %h want %h", bus.first_err_idx, efirst); end
    for (int k = 0; k < n + 8; k++) begin
      ea = exp_aout(k, n, model_aout);
      n_cmp += 3;
      if (busy_obs[k] !== (k < n + 5)) begin n_bad++; $display("[TB] FAIL healthy_busy k=%0d got %b want %b", k, busy_obs[k], (k < n + 5)); end
      if (done_obs[k] !== (k == n + 5)) begin n_bad++; $display("[TB] FAIL healthy_done k=%0d got %b want %b", k, done_obs[k], (k == n + 5)); end
      if (aout_obs[k] !== ea) begin n_bad++; $display("[TB] FAIL healthy_async_out k=%0d got %h want %h", k, aout_obs[k], ea); end
    end
    model_aout = exp_aout(n + 7, n, model_aout);
  endtask

  task automatic test_lane_burst();
    logic [15:0] ecnt, efirst;
    logic [3:0]  elanes;
    int          n;
    n = 50;
    clear_pat();
    for (int j = 10; j <= 12; j++) pat[3 + j] = 4'b0100;
    do_run(n, 1'b0);
    model_results(n, ecnt, elanes, efirst);
    n_cmp += 4;
    if (done_k !== n + 5) begin n_bad++; $display("[TB] FAIL burst_done_period got %0d want %0d", done_k, n + 5); end
    if (bus.err_count !== ecnt) begin n_bad++; $display("[TB] FAIL burst_err_count got %h want %h", bus.err_count, ecnt); end
    if (bus.lane_err !== elanes) begin n_bad++; $display("[TB] FAIL burst_lane_err got %h want %h", bus.lane_err, elanes); end
    if (bus.first_err_idx !== efirst) begin n_bad++; $display("[TB] FAIL burst_first_err got %h want %h", bus.first_err_idx, efirst); end
    model_aout = exp_aout(n + 7, n, model_aout);
  endtask

  task automatic test_flush_ignored();
    logic [15:0] ecnt, efirst;
    logic [3:0]  elanes;
    int          n;
    n = 20;
    clear_pat();
    for (int k = 0; k < 3; k++) pat[k] = 4'b1111;
    do_run(n, 1'b0);
    model_results(n, ecnt, elanes, efirst);
    n_cmp += 2;
    if (bus.err_count !== ecnt) begin n_bad++; $display("[TB] FAIL flush_err_count got %h want %h", bus.err_count, ecnt); end
    if (bus.lane_err !== elanes) begin n_bad++; $display("[TB] FAIL flush_lane_err got %h want %h", bus.lane_err, elanes); end
    model_aout = exp_aout(n + 7, n, model_aout);
  endtask

  task automatic test_zero_len();
    logic [15:0] ecnt, efirst;
    logic [3:0]  elanes;
    clear_pat();
    for (int k = 0; k < 3; k++) pat[k] = 4'($urandom);
    do_run(0, 1'b0);
    model_results(0, ecnt, elanes, efirst);
    n_cmp += 3;
    if (done_k !== 5) begin n_bad++; $display("[TB] FAIL zero_done_period got %0d want 5", done_k); end
    if (bus.err_count !== ecnt) begin n_bad++; $display("[TB] FAIL zero_err_count got %h want %h", bus.err_count, ecnt); end
    if (bus.first_err_idx !== efirst) begin n_bad++; $display("[TB] FAIL zero_first_err got %h want %h", bus.first_err_idx, efirst); end
    for (int k = 0; k < 8; k++) begin
      n_cmp += 1;
      if (aout_obs[k] !== model_aout) begin n_bad++; $display("[TB] FAIL zero_async_out k=%0d got %h want %h", k, aout_obs[k], model_aout); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ecnt, efirst;
    logic [3:0]  elanes, ea;
    int          n;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 60);
      clear_pat();
      for (int k = 0; k < n + 8; k++) pat[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      do_run(n, 1'b0);
      model_results(n, ecnt, elanes, efirst);
      n_cmp += 4;
      if (done_k !== n + 5) begin n_bad++; $display("[TB] FAIL rand%0d_done_period got %0d want %0d", r, done_k, n + 5); end
      if (bus.err_count !== ecnt) begin n_bad++; $display("[TB] FAIL rand%0d_err_count got %h want %h", r, bus.err_count, ecnt); end
      if (bus.lane_err !== elanes) begin n_bad++; $display("[TB] FAIL rand%0d_lane_err got %h want %h", r, bus.lane_err, elanes); end
      if (bus.first_err_idx !== efirst) begin n_bad++; $display("[TB] FAIL rand%0d_first_err got %h want %h", r, bus.first_err_idx, efirst); end
      for (int k = 0; k < n + 8; k++) begin
        ea = exp_aout(k, n, model_aout);
        n_cmp += 1;
        if (aout_obs[k] !== ea) begin n_bad++; $display("[TB] FAIL rand%0d_async_out k=%0d got %h want %h", r, k, aout_obs[k], ea); end
      end
      model_aout = exp_aout(n + 7, n, model_aout);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] s;
    int          cnt, waited;
    sbus.num_vectors = 4'd15;
    sbus.qd_in = 4'b0001;
    sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    waited = 0;
    while (!sbus.done && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp += 1;
    if (!sbus.done) begin n_bad++; $display("[TB] FAIL sat_done_timeout got busy=%b want done", sbus.busy); end
    sbus.qd_in = 4'h0;
    // 15 run cycles plus 2 drain cycles all see an error; the 4-bit count clips
    cnt = 15 + 2;
    if (cnt > 15) cnt = 15;
    s = lfsr_after(16'hACE1, 15);
    n_cmp += 4;
    if (sbus.err_count !== 4'(cnt)) begin n_bad++; $display("[TB] FAIL sat_err_count got %0d want %0d", sbus.err_count, cnt); end
    if (sbus.lane_err !== 4'b0001) begin n_bad++; $display("[TB] FAIL sat_lane_err got %b want 0001", sbus.lane_err); end
    if (sbus.first_err_idx !== 4'h0) begin n_bad++; $display("[TB] FAIL sat_first_err got %h want 0", sbus.first_err_idx); end
    if (sbus.async_out !== s[3:0]) begin n_bad++; $display("[TB] FAIL sat_seed0_async_out got %h want %h", sbus.async_out, s[3:0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_after_reset();
    logic [15:0] ecnt, efirst;
    logic [3:0]  elanes, ea;
    int          n;
    clear_pat();
    bus.num_vectors = 16'd100;
    bus.start = 1'b1;
    bus.qd_in = 4'b0010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (bus.async_out !== 4'h0) begin n_bad++; $display("[TB] FAIL abort_async_out got %h want 0", bus.async_out); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_done got %b want 0", bus.done); end
    if (bus.err_count !== 16'h0) begin n_bad++; $display("[TB] FAIL abort_err_count got %h want 0", bus.err_count); end
    if (bus.lane_err !== 4'h0) begin n_bad++; $display("[TB] FAIL abort_lane_err got %h want 0", bus.lane_err); end
    if (bus.first_err_idx !== 16'h0) begin n_bad++; $display("[TB] FAIL abort_first_err got %h want 0", bus.first_err_idx); end
    bus.qd_in = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_aout = 4'h0;
    n = 100;
    do_run(n, 1'b1);
    model_results(n, ecnt, elanes, efirst);
    n_cmp += 3;
    if (done_k !== n + 5) begin n_bad++; $display("[TB] FAIL restart_done_period got %0d want %0d", done_k, n + 5); end
    if (bus.err_count !== ecnt) begin n_bad++; $display("[TB] FAIL restart_err_count got %h want %h", bus.err_count, ecnt); end
    if (bus.first_err_idx !== efirst) begin n_bad++; $display("[TB] FAIL restart_first_err got %h want %h", bus.first_err_idx, efirst); end
    for (int k = 0; k < n + 8; k++) begin
      ea = exp_aout(k, n, model_aout);
      n_cmp += 3;
      if (busy_obs[k] !== (k < n + 5)) begin n_bad++; $display("[TB] FAIL restart_busy k=%0d got %b want %b", k, busy_obs[k], (k < n + 5)); end
      if (done_obs[k] !== (k == n + 5)) begin n_bad++; $display("[TB] FAIL restart_done k=%0d got %b want %b", k, done_obs[k], (k == n + 5)); end
      if (aout_obs[k] !== ea) begin n_bad++; $display("[TB] FAIL restart_async_out k=%0d got %h want %h", k, aout_obs[k], ea); end
    end
    model_aout = exp_aout(n + 7, n, model_aout);
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_lane_burst();
    test_flush_ignored();
    test_zero_len();
    test_random();
    test_saturation();
    test_restart_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
